// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod;
    logic               neg_a_q;
    logic               neg_b_q;
    logic [CNTW-1:0]    count;

    logic               sgn_a;
    logic               sgn_b;
    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH-1:0]   abs_a_in;
    logic [WIDTH-1:0]   abs_b_in;
    logic               div_zero;
    logic               div_ovf;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'b010:  sgn_a = 1'b1;
            default: ;
        endcase
    end

    assign neg_a_in = sgn_a & a[WIDTH-1];
    assign neg_b_in = sgn_b & b[WIDTH-1];
    assign abs_a_in = neg_a_in ? -a : a;
    assign abs_b_in = neg_b_in ? -b : b;
    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == MOST_NEG) && (b == '1);

    // Multiply keeps {acc, multiplier}; divide keeps {remainder, dividend/quotient}.
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] iter_next;

    always_comb begin
        add_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opnd : {WIDTH{1'b0}})};
        trial     = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {1'b0, opnd};
        iter_next = prod;
        if (op_q[2]) begin
            if (trial[WIDTH])
                iter_next = {prod[2*WIDTH-2:0], 1'b0};
            else
                iter_next = {trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        end else begin
            iter_next = {add_sum, prod[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        prod_s  = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_s   = (neg_a_q ^ neg_b_q) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_s   = neg_a_q ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        fix_res = '0;
        if (op_q[2])
            fix_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00)
            fix_res = prod_s[WIDTH-1:0];
        else
            fix_res = prod_s[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            op_q    <= '0;
            opnd    <= '0;
            prod    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        op_q  <= op;
                        count <= CNTW'(WIDTH);
                        busy  <= 1'b1;
                        // Special cases preload the final quotient/remainder with signs cleared.
                        if (div_zero) begin
                            prod    <= {a, {WIDTH{1'b1}}};
                            neg_a_q <= 1'b0;
                            neg_b_q <= 1'b0;
                            state   <= S_FIX;
                        end else if (div_ovf) begin
                            prod    <= {{WIDTH{1'b0}}, a};
                            neg_a_q <= 1'b0;
                            neg_b_q <= 1'b0;
                            state   <= S_FIX;
                        end else begin
                            neg_a_q <= neg_a_in;
                            neg_b_q <= neg_b_in;
                            opnd    <= op[2] ? abs_b_in : abs_a_in;
                            prod    <= {{WIDTH{1'b0}}, (op[2] ? abs_a_in : abs_b_in)};
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        prod  <= iter_next;
                        count <= count - CNTW'(1);
                        if (count == CNTW'(1))
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy <= 1'b0;
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= fix_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit (WIDTH 32 and 8)
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  result8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .flush(1'b0), .op(op8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(result8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int bn);
        n  = 0;
        bn = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bn++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int lat);
        int n;
        int bn;
        launch(o, x, y);
        wait_done(n, bn);
        check({tag, ":result"}, result, exp);
        check({tag, ":latency"}, 32'(n), 32'(lat));
        check({tag, ":busy_cycles"}, 32'(bn), 32'(lat));
        @(posedge clk);
        #1;
        check({tag, ":done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int bn;
        int seen;
        reset  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        op8    = '0;
        a8     = '0;
        b8     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset:busy", {31'b0, busy}, 32'd0);
        check("reset:done", {31'b0, done}, 32'd0);
        check("reset:result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",   3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_op("mulhu",  3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
        run_op("div",    3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
        run_op("rem",    3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
        run_op("divu",   3'b101, 32'd20, 32'd3, 32'd6, 33);
        run_op("remu",   3'b111, 32'd20, 32'd3, 32'd2, 33);
        run_op("div0",   3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu0",  3'b111, 32'd5, 32'd0, 32'd5, 1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Second start during CALC with other operands must be ignored.
        launch(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        op    = 3'b101;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bn);
        check("ignore_start:result", result, 32'hFFFF_FFEB);
        check("ignore_start:latency", 32'(n), 32'd29);

        // Flush at iteration 10: no done, busy drops, result retained.
        repeat (2) @(posedge clk);
        launch(3'b101, 32'd20, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush:busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("flush:no_done", 32'(seen), 32'd0);
        check("flush:result_kept", result, 32'hFFFF_FFEB);

        // Flush and start together in IDLE: start is dropped.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start:busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-CALC.
        launch(3'b100, 32'hFFFF_FFEC, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset:busy", {31'b0, busy}, 32'd0);
        check("async_reset:done", {31'b0, done}, 32'd0);
        check("async_reset:result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("after_reset", 3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);

        // WIDTH=8 MULHSU.
        @(negedge clk);
        op8    = 3'b010;
        a8     = 8'h80;
        b8     = 8'hFF;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w8_mulhsu:result", {24'b0, result8}, 32'h80);
        check("w8_mulhsu:latency", 32'(n), 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
